writeback_sched: RTL

WRITEBACK_SCHED -- requirements
Module: writeback_sched

---
 rtl/writeback_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/writeback_sched.sv
// Writeback scheduler: tracks in-flight register writes in NSLOT tagged slots,
// blocks WAW hazards at issue and retires the lowest filled slot each cycle.
module writeback_sched #(
   parameter int NSLOT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [1:0]  issue_rw,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   output logic [1:0]  issue_tag,
   input  logic        res_valid,
   input  logic [1:0]  res_tag,
   input  logic [31:0] res_data,
   output logic [1:0]  rwout,
   output logic [4:0]  rdout,
   output logic [31:0] dtowrite,
   input  logic [5:0]  q_rs,
   input  logic [5:0]  q_rt,
   output logic        stall_s,
   output logic        stall_t,
   output logic [2:0]  inflight,
   output logic        err
);

   logic [NSLOT-1:0] alloc_reg;
   logic [NSLOT-1:0] filled_reg;
   logic [NSLOT-1:0] cls_reg;
   logic [4:0]       rd_reg   [NSLOT];
   logic [31:0]      data_reg [NSLOT];

   logic [1:0]  rwout_reg;
   logic [4:0]  rdout_reg;
   logic [31:0] dtowrite_reg;
   logic [2:0]  inflight_reg;
   logic        err_reg;

   logic [NSLOT-1:0] waw_hit, s_hit, t_hit, res_hit, alloc_sel, ret_sel;
   logic             is_write, free_found, ret_found, issue_acc, res_ok;
   logic [1:0]       free_idx, ret_idx;

   assign is_write = (issue_rw == 2'b01) || (issue_rw == 2'b10);

   // Per-slot match vectors; every decision uses registered slot state only.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         assign waw_hit[gi]   = alloc_reg[gi] && ({cls_reg[gi], rd_reg[gi]} == {issue_rw[1], issue_rd});
         assign s_hit[gi]     = alloc_reg[gi] && ({cls_reg[gi], rd_reg[gi]} == q_rs);
         assign t_hit[gi]     = alloc_reg[gi] && ({cls_reg[gi], rd_reg[gi]} == q_rt);
         assign res_hit[gi]   = res_valid && (res_tag == 2'(gi));
         assign alloc_sel[gi] = issue_acc && (free_idx == 2'(gi));
         assign ret_sel[gi]   = ret_found && (ret_idx == 2'(gi));
      end
   endgenerate

   // Lowest-index free slot and lowest-index filled slot.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      ret_found  = 1'b0;
      ret_idx    = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!alloc_reg[i]) begin
            free_found = 1'b1;
            free_idx   = 2'(i);
         end
         if (filled_reg[i]) begin
            ret_found = 1'b1;
            ret_idx   = 2'(i);
         end
      end
   end

   assign issue_ready = !is_write || (free_found && !(|waw_hit));
   assign issue_tag   = free_idx;
   assign issue_acc   = issue_valid && is_write && issue_ready;
   assign res_ok      = |(res_hit & alloc_reg & ~filled_reg);
   assign stall_s     = |s_hit;
   assign stall_t     = |t_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_reg    <= '0;
         filled_reg   <= '0;
         cls_reg      <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            rd_reg[i]   <= '0;
            data_reg[i] <= '0;
         end
         rwout_reg    <= 2'b00;
         rdout_reg    <= '0;
         dtowrite_reg <= '0;
         inflight_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         // Allocation, capture and retire always target distinct slots.
         for (int i = 0; i < NSLOT; i++) begin
            if (alloc_sel[i]) begin
               alloc_reg[i]  <= 1'b1;
               filled_reg[i] <= 1'b0;
               cls_reg[i]    <= issue_rw[1];
               rd_reg[i]     <= issue_rd;
            end
            if (res_hit[i] && alloc_reg[i] && !filled_reg[i]) begin
               filled_reg[i] <= 1'b1;
               data_reg[i]   <= res_data;
            end
            if (ret_sel[i]) begin
               alloc_reg[i]  <= 1'b0;
               filled_reg[i] <= 1'b0;
            end
         end
         if (ret_found) begin
            rwout_reg    <= cls_reg[ret_idx] ? 2'b10 : 2'b01;
            rdout_reg    <= rd_reg[ret_idx];
            dtowrite_reg <= data_reg[ret_idx];
         end else begin
            rwout_reg    <= 2'b00;
         end
         inflight_reg <= inflight_reg + 3'(issue_acc) - 3'(ret_found);
         if (res_valid && !res_ok) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign rwout    = rwout_reg;
   assign rdout    = rdout_reg;
   assign dtowrite = dtowrite_reg;
   assign inflight = inflight_reg;
   assign err      = err_reg;

endmodule
